// File: rtl/md_pkg.sv
// Shared definitions for the sequential multiply/divide unit: mode codes,
// FSM state encoding, default geometry and small mode-decoding helpers.
package md_pkg;

   localparam int MD_DEF_WIDTH   = 32;
   localparam int MD_DEF_MUL_LAT = 5;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MADD  = 3'd4,
      MD_MADDU = 3'd5,
      MD_MSUB  = 3'd6,
      MD_MSUBU = 3'd7
   } md_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   function automatic logic md_is_div(input logic [2:0] m);
      return (m == MD_DIV) || (m == MD_DIVU);
   endfunction

   // Even codes are the signed flavours of every operation pair.
   function automatic logic md_is_signed(input logic [2:0] m);
      return ~m[0];
   endfunction

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider: loads on start_i, WIDTH iterations, done_o high
// the following cycle with sign-corrected quotient/remainder; kill_i aborts.
module md_div_iter
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic             start_i,
   input  logic             kill_i,
   input  logic             sgn_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] r_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic             act_q, act_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;

   logic             a_neg, b_neg;
   logic [WIDTH:0]   shifted;
   logic             fits;

   always_comb begin
      a_neg   = sgn_i & a_i[WIDTH-1];
      b_neg   = sgn_i & b_i[WIDTH-1];
      shifted = {rem_q, quo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvs_q});

      act_d  = act_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      negq_d = negq_q;
      negr_d = negr_q;

      if (kill_i) begin
         act_d = 1'b0;
      end else if (start_i) begin
         // Magnitudes are iterated; the most negative value maps onto 2^(W-1).
         act_d  = 1'b1;
         cnt_d  = CW'(WIDTH);
         rem_d  = '0;
         quo_d  = a_neg ? -a_i : a_i;
         dvs_d  = b_neg ? -b_i : b_i;
         negq_d = a_neg ^ b_neg;
         negr_d = a_neg;
      end else if (act_q) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (fits) begin
               rem_d = shifted[WIDTH-1:0] - dvs_q;
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            act_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         act_q  <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         act_q  <= act_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

   assign done_o = act_q && (cnt_q == '0);
   assign q_o    = negq_q ? -quo_q : quo_q;
   assign r_o    = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide unit: MUL commits MUL_LAT cycles after start, DIV after
// WIDTH+1; shadow copy for rollback. MADD/MSUB codes only with MULDIV_MADD_EN.
module muldiv_seq
   import md_pkg::*;
#(
   parameter int WIDTH   = MD_DEF_WIDTH,
   parameter int MUL_LAT = MD_DEF_MUL_LAT
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             we,
   input  logic             wsel,
   input  logic             stop,
   input  logic             ret,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2 = 2 * WIDTH;

`ifdef MULDIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   md_state_e        state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [2:0]       mode_q, mode_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] shi_q, shi_d, slo_q, slo_d;
   logic             done_q, done_d;

   logic             mode_ok, accept, mul_commit, div_commit;
   logic             div_start, div_kill, div_done;
   logic [WIDTH-1:0] div_q, div_r;
   logic [W2-1:0]    opa_x, opb_x, prod, mul_res;

   assign mode_ok    = MADD_EN || !mode[2];
   assign accept     = start && mode_ok && (state_q == ST_IDLE) && !stop && !ret;
   assign div_start  = accept && md_is_div(mode);
   assign div_kill   = stop || ret;
   assign mul_commit = (state_q == ST_MUL) && (cnt_q == '0);
   assign div_commit = (state_q == ST_DIV) && div_done;

   md_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk     (clk),
      .clr     (clr),
      .start_i (div_start),
      .kill_i  (div_kill),
      .sgn_i   (md_is_signed(mode)),
      .a_i     (a),
      .b_i     (b),
      .done_o  (div_done),
      .q_o     (div_q),
      .r_o     (div_r)
   );

   // Product is evaluated from the latched operands; it only needs to settle by the commit edge.
   always_comb begin
      opa_x   = {{WIDTH{md_is_signed(mode_q) & opa_q[WIDTH-1]}}, opa_q};
      opb_x   = {{WIDTH{md_is_signed(mode_q) & opb_q[WIDTH-1]}}, opb_q};
      prod    = opa_x * opb_x;
      mul_res = prod;
      if (MADD_EN && mode_q[2]) begin
         mul_res = mode_q[1] ? (acc_q - prod) : (acc_q + prod);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      shi_d   = shi_q;
      slo_d   = slo_q;
      done_d  = 1'b0;

      if (ret) begin
         hi_d    = shi_q;
         lo_d    = slo_q;
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (mul_commit || div_commit) begin
         shi_d   = hi_q;
         slo_d   = lo_q;
         done_d  = 1'b1;
         state_d = ST_IDLE;
         cnt_d   = '0;
         if (mul_commit) begin
            {hi_d, lo_d} = mul_res;
         end else if (opb_q != '0) begin
            hi_d = div_r;
            lo_d = div_q;
         end
      end else if (accept) begin
         opa_d   = a;
         opb_d   = b;
         mode_d  = mode;
         acc_d   = {hi_q, lo_q};
         state_d = md_is_div(mode) ? ST_DIV : ST_MUL;
         cnt_d   = 5'(MUL_LAT - 1);
      end else if (we && (state_q == ST_IDLE)) begin
         shi_d = hi_q;
         slo_d = lo_q;
         if (wsel) hi_d = a;
         else      lo_d = a;
      end else if (state_q == ST_MUL) begin
         cnt_d = cnt_q - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         mode_q  <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         shi_q   <= '0;
         slo_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         shi_q   <= shi_d;
         slo_q   <= slo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed scenarios plus randomized ops, with a queue
// scoreboard checked by a monitor on every done pulse.
module tb_muldiv_seq;

   localparam int W   = 32;
   localparam int LAT = 5;

`ifdef MULDIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         clr, start, we, wsel, stop, ret;
   logic [2:0]   mode;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(W), .MUL_LAT(LAT)) dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .we    (we),
      .wsel  (wsel),
      .stop  (stop),
      .ret   (ret),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           scyc;
      int           lat;
   } exp_t;

   exp_t         exp_q[$];
   int           nchk = 0;
   int           npass = 0;
   int           cyc = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0, m_shi = '0, m_slo = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      nchk++;
      if (act === req) npass++;
      else $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
   endtask

   // Architectural reference: what HI/LO must hold after the operation.
   function automatic void model(input logic [2:0] m, input logic [W-1:0] oa, ob, ih, il,
                                 output bit acc, output logic [W-1:0] nh, nl, output int lat);
      longint       sa, sb;
      logic [63:0]  p, hl;
      int           qa, qb;
      acc = 1'b1;
      nh  = ih;
      nl  = il;
      hl  = {ih, il};
      sa  = longint'($signed(oa));
      sb  = longint'($signed(ob));
      lat = (m == 3'd2 || m == 3'd3) ? W + 1 : LAT;
      p   = m[0] ? ({32'b0, oa} * {32'b0, ob}) : 64'(sa * sb);
      case (m)
         3'd0, 3'd1: {nh, nl} = p;
         3'd2: begin
            if (ob != 0) begin
               if (oa == 32'h8000_0000 && ob == 32'hFFFF_FFFF) begin
                  nl = oa;
                  nh = 0;
               end else begin
                  qa = $signed(oa);
                  qb = $signed(ob);
                  nl = qa / qb;
                  nh = qa % qb;
               end
            end
         end
         3'd3: begin
            if (ob != 0) begin
               nl = oa / ob;
               nh = oa % ob;
            end
         end
         default: begin
            if (!MADD_EN) acc = 1'b0;
            else {nh, nl} = (m >= 3'd6) ? hl - p : hl + p;
         end
      endcase
   endfunction

   // Called at a negedge; drives start for one cycle and posts the expectation.
   task automatic launch(input logic [2:0] m, input logic [W-1:0] oa, ob, output bit acc, output int lat);
      logic [W-1:0] nh, nl;
      exp_t         e;
      model(m, oa, ob, m_hi, m_lo, acc, nh, nl, lat);
      start = 1'b1;
      mode  = m;
      a     = oa;
      b     = ob;
      if (acc) begin
         e.hi   = nh;
         e.lo   = nl;
         e.scyc = cyc + 1;
         e.lat  = lat;
         exp_q.push_back(e);
         m_shi = m_hi;
         m_slo = m_lo;
         m_hi  = nh;
         m_lo  = nl;
      end
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      mode  = 3'($urandom);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [2:0] m, input logic [W-1:0] oa, ob);
      bit           acc;
      int           lat, n;
      logic [W-1:0] h0, l0;
      h0 = m_hi;
      l0 = m_lo;
      launch(m, oa, ob, acc, lat);
      wait_idle(n);
      if (acc) begin
         check("busy_cycles", 64'(n), 64'(lat));
      end else begin
         check("ignored_busy", 64'(n), 64'd0);
         check("ignored_hi", 64'(hi), 64'(h0));
         check("ignored_lo", 64'(lo), 64'(l0));
      end
   endtask

   task automatic do_we(input logic sel, input logic [W-1:0] val);
      we   = 1'b1;
      wsel = sel;
      a    = val;
      m_shi = m_hi;
      m_slo = m_lo;
      if (sel) m_hi = val;
      else     m_lo = val;
      @(negedge clk);
      we = 1'b0;
      check("we_hi", 64'(hi), 64'(m_hi));
      check("we_lo", 64'(lo), 64'(m_lo));
   endtask

   task automatic do_ret();
      ret  = 1'b1;
      m_hi = m_shi;
      m_lo = m_slo;
      @(negedge clk);
      ret = 1'b0;
      check("ret_hi", 64'(hi), 64'(m_hi));
      check("ret_lo", 64'(lo), 64'(m_lo));
   endtask

   function automatic logic [W-1:0] rnd_opnd();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20)) - 32'd10;
         default: return 32'($urandom);
      endcase
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: every done pulse must match the oldest posted expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            nchk++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
         end else begin
            e = exp_q.pop_front();
            check("commit_hi", 64'(hi), 64'(e.hi));
            check("commit_lo", 64'(lo), 64'(e.lo));
            check("commit_latency", 64'(cyc - e.scyc), 64'(e.lat));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not complete, required finish within budget");
      $fatal(1);
   end

   initial begin
      bit           acc;
      int           lat, n;
      logic [W-1:0] h0, l0, s0h, s0l;

      clr = 1'b1; start = 1'b0; we = 1'b0; wsel = 1'b0; stop = 1'b0; ret = 1'b0;
      mode = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      clr = 1'b0;
      @(negedge clk);

      // Signed multiply of a negative operand
      run_op(3'd0, -32'sd3, 32'd7);
      check("case1_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("case1_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);

      // Signed divide, then unsigned divide by zero
      run_op(3'd2, -32'sd7, 32'd2);
      check("case2_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      check("case2_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      run_op(3'd3, 32'd7, 32'd0);
      check("divz_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("divz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

      // MADDU carry from LO into HI (ignored when accumulate ops are absent)
      do_we(1'b1, 32'd0);
      do_we(1'b0, 32'hFFFF_FFFF);
      run_op(3'd5, 32'd1, 32'd1);
      check("case3_hi", 64'(hi), MADD_EN ? 64'd1 : 64'd0);
      check("case3_lo", 64'(lo), MADD_EN ? 64'd0 : 64'h0000_0000_FFFF_FFFF);

      // Abort a divide with stop, then a MULT right away
      h0 = m_hi; l0 = m_lo; s0h = m_shi; s0l = m_slo;
      launch(3'd2, 32'($urandom), 32'd3, acc, lat);
      repeat (9) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      void'(exp_q.pop_back());
      m_hi = h0; m_lo = l0; m_shi = s0h; m_slo = s0l;
      check("stop_busy", 64'(busy), 64'd0);
      check("stop_hi", 64'(hi), 64'(h0));
      check("stop_lo", 64'(lo), 64'(l0));
      run_op(3'd1, 32'($urandom), 32'($urandom));

      // MTLO then rollback; MTLO while busy must be dropped
      do_we(1'b0, 32'd1234);
      do_ret();
      launch(3'd0, 32'($urandom), 32'($urandom), acc, lat);
      we = 1'b1; wsel = 1'b0; a = 32'hDEAD_BEEF;
      @(negedge clk);
      we = 1'b0;
      wait_idle(n);
      check("we_busy_lo", 64'(lo), 64'(m_lo));
      do_ret();

      // Asynchronous clear mid-multiply
      launch(3'd0, 32'($urandom), 32'($urandom), acc, lat);
      @(negedge clk);
      clr = 1'b1;
      #1;
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_done", 64'(done), 64'd0);
      check("clr_hi", 64'(hi), 64'd0);
      check("clr_lo", 64'(lo), 64'd0);
      void'(exp_q.pop_back());
      m_hi = '0; m_lo = '0; m_shi = '0; m_slo = '0;
      @(negedge clk);
      clr = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      check("clr_after_busy", 64'(busy), 64'd0);

      // Randomized mix of operations, writes and rollbacks, some back-to-back
      for (int i = 0; i < 60; i++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k < 8)       run_op(3'(k), rnd_opnd(), rnd_opnd());
         else if (k == 8) do_we(1'($urandom), 32'($urandom));
         else             do_ret();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width (8..64).
REQ-002 Parameter MUL_LAT, default 5, multiply/accumulate latency in cycles (1..31).
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  launch request for the operation selected by mode.
REQ-006 mode  input  3  operation: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU (codes 0..7).
REQ-007 a, b  input  WIDTH each  operands; a is also the write data for we.
REQ-008 we  input  1  direct register write (MTHI/MTLO).
REQ-009 wsel  input  1  write target: 0 = LO, 1 = HI.
REQ-010 stop  input  1  cancel the in-flight operation (pipeline flush).
REQ-011 ret  input  1  restore HI/LO from the shadow copy (exception rollback).
REQ-012 busy  output  1  operation in flight.
REQ-013 done  output  1  one-cycle pulse in the cycle HI/LO take a result.
REQ-014 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 FSM states: IDLE, MUL, DIV; start is accepted only in IDLE and is ignored otherwise.
REQ-016 Accepted start latches a, b and mode, enters MUL (codes 0,1,4..7) or DIV (codes 2,3), and asserts busy from the next cycle.
REQ-017 MUL commits {hi,lo} exactly MUL_LAT cycles after the start edge; busy drops and done pulses in that same cycle.
REQ-018 MULT/MULTU return the signed/unsigned 2*WIDTH product.
REQ-019 MADD(U)/MSUB(U) return {hi,lo} +/- product, computed modulo 2^(2*WIDTH) against {hi,lo} as sampled at the start edge.
REQ-020 DIV/DIVU run a radix-2 restoring iteration of one bit per cycle and commit after WIDTH+1 cycles.
REQ-021 Division results: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-022 Divide by zero: the operation still takes full latency, and hi/lo stay unchanged at completion (done still pulses).
REQ-023 Signed overflow case (most negative value / -1): lo = most negative value, hi = 0.
REQ-024 we is honoured only in IDLE; it is ignored while busy, and start has priority when both arrive in the same cycle.
REQ-025 Before every commit or honoured we, the shadow registers take the current hi/lo.
REQ-026 stop aborts in any state: next cycle is IDLE with busy = 0 and no done; hi/lo are unchanged.
REQ-027 ret copies shadow into hi/lo; if an operation is in flight, ret also aborts it like stop.
REQ-028 Priority per edge: clr > ret > stop > commit > start > we.
REQ-029 start in the cycle after done is accepted, giving back-to-back operation with no bubble.

Reset
REQ-030 While clr is high: state = IDLE, hi = lo = 0, shadow = 0, busy = 0, done = 0, counter = 0.
REQ-031 A clr mid-operation discards the operation with no done pulse.

Configuration
REQ-032 The macro MULDIV_MADD_EN compiles in codes 4..7.
REQ-033 Without MULDIV_MADD_EN, start with codes 4..7 is ignored: it stays in IDLE, busy stays 0, and hi/lo are untouched.

Structure
REQ-034 The md_pkg package holds the mode encodings, FSM state typedef and default latencies.
REQ-035 The iterative divider is a sub-module md_div_iter (start/done handshake, signed pre/post correction).

Verification
REQ-036 Case 1: WIDTH=32, MULT a=-3, b=7 -> busy for 5 cycles, then hi=FFFFFFFF, lo=FFFFFFEB, done for 1 cycle.
REQ-037 Case 2: DIV a=-7, b=2 -> after 33 cycles, lo=FFFFFFFD, hi=FFFFFFFF; then DIVU a=7, b=0 -> hi/lo unchanged, done still pulses.
REQ-038 Case 3: hi=0, lo=FFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0; without MULDIV_MADD_EN, busy stays 0.
REQ-039 Case 4: start DIV, then stop on cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged; immediate new MULT completes normally.
REQ-040 Case 5: we with wsel=0, a=1234 (lo was 0), then ret -> lo=0; we during busy -> ignored.
REQ-041 Case 6: assert clr mid-MUL -> all outputs 0 asynchronously, no done after release.
